// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the decimal-adder sharing controller.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int MANT_W      = 34;
  localparam int EXP_W       = 7;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;

  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Round-robin winner search: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the farthest candidate down so the one nearest ptr wins.
  always_comb begin
    int  j;
    logic hit;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    hit   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j     = (int'(ptr) + k) % NREQ;
      hit   = req[j];
      valid = valid | hit;
      idx   = hit ? IDX_W'(j) : idx;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing controller for one decimal adder; drives eval, waits for done.
// Optional adder watchdog enabled by defining ADDER_ARB_TIMEOUT_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         sub,
  input  logic [NREQ-1:0]         reqSignA,
  input  logic [NREQ-1:0]         reqSignB,
  input  logic [NREQ*MANT_W-1:0]  reqMantA,
  input  logic [NREQ*MANT_W-1:0]  reqMantB,
  input  logic [NREQ*EXP_W-1:0]   reqExpA,
  input  logic [NREQ*EXP_W-1:0]   reqExpB,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic                    resSign,
  output logic [MANT_W-1:0]       resMant,
  output logic [EXP_W-1:0]        resExp,
  output logic                    busy,
  output logic                    eval,
  input  logic                    done,
  output logic                    signA,
  output logic                    signB,
  output logic [MANT_W-1:0]       mantA,
  output logic [MANT_W-1:0]       mantB,
  output logic [EXP_W-1:0]        expA,
  output logic [EXP_W-1:0]        expB,
  input  logic                    signRes,
  input  logic [MANT_W-1:0]       mantRes,
  input  logic [EXP_W-1:0]        expRes
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_t        state_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [IDX_W-1:0]  grant_r;
  logic              eval_r;
  logic [NREQ-1:0]   ack_r;
  logic              busy_r;
  logic              sign_a_r;
  logic              sign_b_r;
  logic [MANT_W-1:0] mant_a_r;
  logic [MANT_W-1:0] mant_b_r;
  logic [EXP_W-1:0]  exp_a_r;
  logic [EXP_W-1:0]  exp_b_r;
  logic              res_sign_r;
  logic [MANT_W-1:0] res_mant_r;
  logic [EXP_W-1:0]  res_exp_r;

  logic              pick_valid_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic [MANT_W-1:0] pick_mant_a_s;
  logic [MANT_W-1:0] pick_mant_b_s;
  logic [EXP_W-1:0]  pick_exp_a_s;
  logic [EXP_W-1:0]  pick_exp_b_s;
  logic [NREQ-1:0]   grant_onehot_s;

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  logic             err_r;
  logic [CNT_W-1:0] wait_cnt_r;
`endif

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign pick_mant_a_s  = reqMantA[pick_idx_s*MANT_W +: MANT_W];
  assign pick_mant_b_s  = reqMantB[pick_idx_s*MANT_W +: MANT_W];
  assign pick_exp_a_s   = reqExpA[pick_idx_s*EXP_W +: EXP_W];
  assign pick_exp_b_s   = reqExpB[pick_idx_s*EXP_W +: EXP_W];
  assign grant_onehot_s = NREQ'(1) << grant_r;

  // Controller FSM: grant, one-cycle eval, wait for done (or watchdog), acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      grant_r    <= '0;
      eval_r     <= 1'b0;
      ack_r      <= '0;
      busy_r     <= 1'b0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      mant_a_r   <= '0;
      mant_b_r   <= '0;
      exp_a_r    <= '0;
      exp_b_r    <= '0;
      res_sign_r <= 1'b0;
      res_mant_r <= '0;
      res_exp_r  <= '0;
`ifdef ADDER_ARB_TIMEOUT_EN
      err_r      <= 1'b0;
      wait_cnt_r <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= '0;
          if (pick_valid_s) begin
            grant_r  <= pick_idx_s;
            sign_a_r <= reqSignA[pick_idx_s];
            sign_b_r <= reqSignB[pick_idx_s] ^ sub[pick_idx_s];
            mant_a_r <= pick_mant_a_s;
            mant_b_r <= pick_mant_b_s;
            exp_a_r  <= pick_exp_a_s;
            exp_b_r  <= pick_exp_b_s;
            eval_r   <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ISSUE;
`ifdef ADDER_ARB_TIMEOUT_EN
            err_r    <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          eval_r  <= 1'b0;
          state_r <= WAIT;
`ifdef ADDER_ARB_TIMEOUT_EN
          wait_cnt_r <= '0;
`endif
        end
        WAIT: begin
          eval_r <= 1'b0;
          if (done) begin
            res_sign_r <= signRes;
            res_mant_r <= mantRes;
            res_exp_r  <= expRes;
            ack_r      <= grant_onehot_s;
            state_r    <= RESP;
          end
`ifdef ADDER_ARB_TIMEOUT_EN
          // Watchdog fires on the TIMEOUT-th WAIT cycle without done.
          else if (wait_cnt_r == TO_LIM - 8'd1) begin
            res_sign_r <= 1'b0;
            res_mant_r <= '0;
            res_exp_r  <= '0;
            err_r      <= 1'b1;
            ack_r      <= grant_onehot_s;
            state_r    <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
`endif
        end
        RESP: begin
          ack_r   <= '0;
          ptr_r   <= IDX_W'(wrap_inc(int'(grant_r), NREQ));
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          eval_r  <= 1'b0;
          ack_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ack     = ack_r;
  assign busy    = busy_r;
  assign eval    = eval_r;
  assign signA   = sign_a_r;
  assign signB   = sign_b_r;
  assign mantA   = mant_a_r;
  assign mantB   = mant_b_r;
  assign expA    = exp_a_r;
  assign expB    = exp_b_r;
  assign resSign = res_sign_r;
  assign resMant = res_mant_r;
  assign resExp  = res_exp_r;
`ifdef ADDER_ARB_TIMEOUT_EN
  assign err     = err_r;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter with a behavioural decimal adder stub and ack scoreboard.
module tb_adder_arbiter;

  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req, sub, reqSignA, reqSignB;
  logic [N*34-1:0] reqMantA, reqMantB;
  logic [N*7-1:0]  reqExpA, reqExpB;
  logic [N-1:0]  ack;
  logic          err, resSign, busy, eval, done;
  logic [33:0]   resMant, mantA, mantB, mantRes;
  logic [6:0]    resExp, expA, expB, expRes;
  logic          signA, signB, signRes;

  adder_arbiter #(.NREQ(N), .TIMEOUT(20)) dut (
    .clock(clock), .reset(reset), .req(req), .sub(sub),
    .reqSignA(reqSignA), .reqSignB(reqSignB), .reqMantA(reqMantA), .reqMantB(reqMantB),
    .reqExpA(reqExpA), .reqExpB(reqExpB), .ack(ack), .err(err),
    .resSign(resSign), .resMant(resMant), .resExp(resExp), .busy(busy), .eval(eval),
    .done(done), .signA(signA), .signB(signB), .mantA(mantA), .mantB(mantB),
    .expA(expA), .expB(expB), .signRes(signRes), .mantRes(mantRes), .expRes(expRes)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic        s;
    logic [33:0] m;
    logic [6:0]  e;
    logic        er;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  typedef struct {
    int          idx;
    logic        sub;
    logic        sa;
    logic [33:0] ma;
    logic [6:0]  ea;
    logic        sbb;
    logic [33:0] mb;
    logic [6:0]  eb;
    logic        seen_sb;
    logic        rs;
    logic [33:0] rm;
    logic [6:0]  re;
  } vec_t;
  vec_t vt[6];

  // Reference decimal add: align to the smaller exponent, signed sum, zero -> (+, 0, e0).
  function automatic void dec_add(input logic sa, input logic [33:0] ma, input logic [6:0] ea,
                                  input logic sbb, input logic [33:0] mb, input logic [6:0] eb,
                                  output logic rs, output logic [33:0] rm, output logic [6:0] re);
    int e1, e2, emin;
    longint va, vb, s;
    e1 = $signed(ea);
    e2 = $signed(eb);
    emin = (e1 < e2) ? e1 : e2;
    va = longint'(ma);
    vb = longint'(mb);
    repeat (e1 - emin) va = va * 10;
    repeat (e2 - emin) vb = vb * 10;
    if (sa) va = -va;
    if (sbb) vb = -vb;
    s = va + vb;
    if (s == 0) begin
      rs = 1'b0; rm = 34'd0; re = 7'd0;
    end else begin
      rs = (s < 0);
      rm = 34'((s < 0) ? -s : s);
      re = 7'(emin);
    end
  endfunction

  // Adder stub: latches operands on eval, raises done after stub_lat cycles.
  logic stub_done = 1'b0, spur_done = 1'b0;
  int   stub_cnt = 0, stub_lat = 1;
  bit   stub_en = 1'b1;
  logic st_sa, st_sb;
  logic [33:0] st_ma, st_mb;
  logic [6:0]  st_ea, st_eb;
  assign done = stub_done | spur_done;

  always @(negedge clock) begin
    if (reset) begin
      stub_cnt = 0; stub_done = 1'b0;
      signRes = 1'b0; mantRes = 34'd0; expRes = 7'd0;
    end else begin
      stub_done = 1'b0;
      if (eval) begin
        st_sa = signA; st_sb = signB; st_ma = mantA; st_mb = mantB; st_ea = expA; st_eb = expB;
        stub_cnt = stub_lat;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0 && stub_en) begin
          dec_add(st_sa, st_ma, st_ea, st_sb, st_mb, st_eb, signRes, mantRes, expRes);
          stub_done = 1'b1;
        end
      end
    end
  end

  // Scoreboard: every ack pops the oldest expectation.
  always @(negedge clock) begin
    if (!reset && ack != 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack got ack=%b", ack);
      end else begin
        cur = sb.pop_front();
        if (ack !== (4'b0001 << cur.idx) || resSign !== cur.s || resMant !== cur.m ||
            resExp !== cur.e || err !== cur.er) begin
          failures++;
          $display("FAIL ack_result got ack=%b s=%b m=%0d e=%0d err=%b want ack=%b s=%b m=%0d e=%0d err=%b",
                   ack, resSign, resMant, resExp, err, 4'b0001 << cur.idx, cur.s, cur.m, cur.e, cur.er);
        end
      end
    end
  end

  // eval must be a single-cycle pulse with at least two low cycles between pulses.
  int hi_len = 0, lo_len = 100;
  always @(negedge clock) begin
    if (reset) begin
      hi_len = 0; lo_len = 100;
    end else if (eval) begin
      if (hi_len == 0) begin
        checks++;
        if (lo_len < 2) begin failures++; $display("FAIL eval_gap got %0d want >=2", lo_len); end
      end
      hi_len++; lo_len = 0;
    end else begin
      if (hi_len > 0) begin
        checks++;
        if (hi_len != 1) begin failures++; $display("FAIL eval_width got %0d want 1", hi_len); end
      end
      hi_len = 0; lo_len++;
    end
  end

  function automatic void push_exp(input int idx, input logic s, input logic [33:0] m,
                                   input logic [6:0] e, input logic er);
    exp_t x;
    x.idx = idx; x.s = s; x.m = m; x.e = e; x.er = er;
    sb.push_back(x);
  endfunction

  task automatic set_ops(input int i, input logic sb_sub, input logic sa, input logic [33:0] ma,
                         input logic [6:0] ea, input logic sbb, input logic [33:0] mb, input logic [6:0] eb);
    sub[i] = sb_sub; reqSignA[i] = sa; reqSignB[i] = sbb;
    reqMantA[i*34 +: 34] = ma; reqMantB[i*34 +: 34] = mb;
    reqExpA[i*7 +: 7] = ea; reqExpB[i*7 +: 7] = eb;
  endtask

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Waits for n ack pulses (bounded); optionally drops each acked request in its ack cycle.
  task automatic run_acks(input int n, input bit drop);
    int seen = 0;
    for (int c = 0; c < 200 && seen < n; c++) begin
      @(negedge clock);
      if (ack != 4'b0000) begin
        seen++;
        if (drop) req = req & ~ack;
      end
    end
    if (seen < n) begin
      checks++; failures++;
      $display("FAIL ack_timeout got %0d acks want %0d", seen, n);
    end
  endtask

  logic        trs;
  logic [33:0] trm;
  logic [6:0]  tre;
  int          n;
  bit          any_ack;

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vt[0] = '{0, 1'b0, 1'b0, 34'd12, 7'd0, 1'b0, 34'd3, 7'd0, 1'b0, 1'b0, 34'd15, 7'd0};
    vt[1] = '{2, 1'b1, 1'b0, 34'd12, 7'd0, 1'b0, 34'd3, 7'd0, 1'b1, 1'b0, 34'd9, 7'd0};
    vt[2] = '{2, 1'b1, 1'b0, 34'd12, 7'd0, 1'b1, 34'd3, 7'd0, 1'b0, 1'b0, 34'd15, 7'd0};
    vt[3] = '{1, 1'b0, 1'b0, 34'd5, 7'd1, 1'b0, 34'd7, 7'd0, 1'b0, 1'b0, 34'd57, 7'd0};
    vt[4] = '{3, 1'b1, 1'b0, 34'd3, 7'd0, 1'b0, 34'd3, 7'd0, 1'b1, 1'b0, 34'd0, 7'd0};
    vt[5] = '{0, 1'b0, 1'b1, 34'd7, 7'h7D, 1'b0, 34'd2, 7'h7D, 1'b0, 1'b1, 34'd5, 7'h7D};

    reset = 1'b1; req = '0; sub = '0; reqSignA = '0; reqSignB = '0;
    reqMantA = '0; reqMantB = '0; reqExpA = '0; reqExpB = '0;
    repeat (2) @(negedge clock);
    check("reset_outputs", longint'({ack, err, busy, eval, resMant, mantA, mantB}), 0);
    reset = 1'b0;

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) begin
      set_ops(vt[i].idx, vt[i].sub, vt[i].sa, vt[i].ma, vt[i].ea, vt[i].sbb, vt[i].mb, vt[i].eb);
      push_exp(vt[i].idx, vt[i].rs, vt[i].rm, vt[i].re, 1'b0);
      req[vt[i].idx] = 1'b1;
      run_acks(1, 1'b1);
      check("adder_signB", longint'(st_sb), longint'(vt[i].seen_sb));
      repeat (2) @(negedge clock);
      check("result_hold", longint'({busy, resSign, resMant, resExp}), longint'({1'b0, vt[i].rs, vt[i].rm, vt[i].re}));
    end

    // Fairness: all four requesting from a fresh reset.
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 1'b0, 1'b0, 34'(i + 1), 7'd0, 1'b0, 34'd10, 7'd0);
    push_exp(0, 1'b0, 34'd11, 7'd0, 1'b0); push_exp(1, 1'b0, 34'd12, 7'd0, 1'b0);
    push_exp(2, 1'b0, 34'd13, 7'd0, 1'b0); push_exp(3, 1'b0, 34'd14, 7'd0, 1'b0);
    push_exp(0, 1'b0, 34'd11, 7'd0, 1'b0); push_exp(1, 1'b0, 34'd12, 7'd0, 1'b0);
    push_exp(3, 1'b0, 34'd14, 7'd0, 1'b0); push_exp(1, 1'b0, 34'd12, 7'd0, 1'b0);
    req = 4'b1111;
    run_acks(6, 1'b0);
    req = 4'b1010;
    run_acks(2, 1'b0);
    req = 4'b0000;

    // Back-to-back on requester 1 with fresh operands after each ack.
    stub_lat = 3;
    for (int k = 0; k < 3; k++) begin
      set_ops(1, 1'(k), 1'b0, 34'(k + 2), 7'd1, 1'b0, 34'(k), 7'd0);
      dec_add(1'b0, 34'(k + 2), 7'd1, 1'(k), 34'(k), 7'd0, trs, trm, tre);
      push_exp(1, trs, trm, tre, 1'b0);
      req[1] = 1'b1;
      run_acks(1, 1'b0);
    end
    req = 4'b0000;

    // done while idle must be ignored.
    @(negedge clock); spur_done = 1'b1; @(negedge clock); spur_done = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_done_busy", longint'(busy), 0);

    // Reset while the adder is computing.
    stub_lat = 10;
    set_ops(2, 1'b0, 1'b1, 34'd99, 7'd2, 1'b0, 34'd1, 7'd0);
    req[2] = 1'b1;
    repeat (4) @(negedge clock);
    check("busy_in_wait", longint'(busy), 1);
    reset = 1'b1; req = 4'b0000;
    #1;
    check("reset_mid_wait", longint'({ack, err, busy, eval, signA, signB, mantA, mantB, expA, expB}), 0);
    check("reset_mid_wait_res", longint'({resSign, resMant, resExp}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0; stub_lat = 1;
    set_ops(1, 1'b0, 1'b0, 34'd4, 7'd0, 1'b0, 34'd4, 7'd0);
    set_ops(3, 1'b1, 1'b0, 34'd20, 7'd0, 1'b1, 34'd5, 7'd0);
    push_exp(1, 1'b0, 34'd8, 7'd0, 1'b0);
    push_exp(3, 1'b0, 34'd25, 7'd0, 1'b0);
    req = 4'b1010;
    run_acks(2, 1'b1);

`ifdef ADDER_ARB_TIMEOUT_EN
    // Watchdog: stub never answers, ack must arrive 21 cycles after eval.
    stub_en = 1'b0;
    set_ops(0, 1'b0, 1'b0, 34'd5, 7'd0, 1'b0, 34'd6, 7'd0);
    push_exp(0, 1'b0, 34'd0, 7'd0, 1'b1);
    req[0] = 1'b1;
    any_ack = 1'b0;
    for (int c = 0; c < 10 && !any_ack; c++) begin @(negedge clock); any_ack = eval; end
    n = 0; any_ack = 1'b0;
    for (int c = 0; c < 60 && !any_ack; c++) begin @(negedge clock); n++; any_ack = ack[0]; end
    req[0] = 1'b0;
    check("timeout_latency", longint'(n), 21);
    @(negedge clock); spur_done = 1'b1; @(negedge clock); spur_done = 1'b0;
    stub_en = 1'b1;
`endif

    repeat (4) @(negedge clock);
    check("err_held", longint'(err),
`ifdef ADDER_ARB_TIMEOUT_EN
          1
`else
          0
`endif
    );
    check("scoreboard_empty", longint'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
